// File: rtl/count_pkg.sv
// Shared encodings for the counter-sequence checker.
//   mode_e        : detected counting sequence; matches the counter-select encoding
//   delta_class_e : classification of (count - prev) mod 16. The four sequence
//                   classes use the same values as mode_e, so a class converts to
//                   a mode by taking its low two bits.
package count_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_EVEN = 2'b10,
    MODE_ODD  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    CLS_UP      = 3'd0,
    CLS_DOWN    = 3'd1,
    CLS_EVEN    = 3'd2,
    CLS_ODD     = 3'd3,
    CLS_STALL   = 3'd4,
    CLS_INVALID = 3'd5
  } delta_class_e;

  // True for the four classes that describe a counting sequence.
  function automatic logic is_seq_class(delta_class_e c);
    return (c == CLS_UP) || (c == CLS_DOWN) || (c == CLS_EVEN) || (c == CLS_ODD);
  endfunction

  // Only meaningful when is_seq_class(c) is true.
  function automatic mode_e class_to_mode(delta_class_e c);
    logic [2:0] raw;
    raw = c;
    return mode_e'(raw[1:0]);
  endfunction

endpackage

// File: rtl/count_seq_checker_if.sv
// Sample/result bundle of the counter-sequence checker.
//   sample  : one-cycle strobe, count is valid this cycle
//   count   : 4-bit counter value under observation
//   mode    : detected sequence (up/down/even/odd)
//   locked  : mode is valid and the sequence is being checked
//   err     : one-cycle pulse on a sequence violation while locked
//   wrap    : one-cycle pulse when a locked sequence wraps modulo 16
//   err_cnt : saturating violation count, ERR_W bits
// master drives the samples, slave is the checker.
interface count_seq_checker_if
  import count_pkg::*;
#(
  parameter int ERR_W = 8
);
  logic             sample;
  logic [3:0]       count;
  mode_e            mode;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output sample, count,
    input  mode, locked, err, wrap, err_cnt
  );

  modport slave (
    input  sample, count,
    output mode, locked, err, wrap, err_cnt
  );
endinterface

// File: rtl/count_delta_classify.sv
// Combinational classifier for the step between two successive counter samples.
//   count       : current sample
//   prev        : last accepted sample
//   delta_class : UP (+1), DOWN (-1), EVEN/ODD (+2, by parity of count),
//                 STALL (0) or INVALID (anything else), all modulo 16
module count_delta_classify
  import count_pkg::*;
(
  input  logic [3:0]   count,
  input  logic [3:0]   prev,
  output delta_class_e delta_class
);

  logic [3:0] delta;

  // Four-bit subtraction wraps naturally, giving the step modulo 16.
  assign delta = count - prev;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    delta_class = CLS_INVALID;
    case (delta)
      4'd0:    delta_class = CLS_STALL;
      4'd1:    delta_class = CLS_UP;
      4'd15:   delta_class = CLS_DOWN;
      4'd2:    delta_class = count[0] ? CLS_ODD : CLS_EVEN;
      default: delta_class = CLS_INVALID;
    endcase
  end

endmodule

// File: rtl/count_seq_checker.sv
// Counter-sequence checker. Watches a sampled 4-bit counter, learns which
// sequence it follows (up, down, even, odd) after two identical consecutive
// steps, then flags every step that breaks the sequence.
//   clk   : system clock, rising edge
//   Clear : asynchronous active-high reset
//   bus   : count_seq_checker_if.slave (sample/count in, mode/locked/err/wrap/err_cnt out)
// All outputs come straight from flops; they update one cycle after the sample.
module count_seq_checker
  import count_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input logic                clk,
  input logic                Clear,
  count_seq_checker_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no previous sample yet
    ACQ1  = 2'd1,  // previous sample held, no candidate sequence
    ACQ2  = 2'd2,  // candidate sequence seen once
    LOCK  = 2'd3   // sequence confirmed, checking every step
  } state_e;

  state_e           state;
  logic [3:0]       prev;
  mode_e            cand;
  mode_e            mode_q;
  logic             locked_q;
  logic             err_q;
  logic             wrap_q;
  logic [ERR_W-1:0] err_cnt_q;

  delta_class_e cls;
  logic         is_stall;
  logic         is_seq;
  logic         match_cand;
  logic         match_mode;
  logic         wraps;

  count_delta_classify u_classify (
    .count       (bus.count),
    .prev        (prev),
    .delta_class (cls)
  );

  assign is_stall   = (cls == CLS_STALL);
  assign is_seq     = is_seq_class(cls);
  assign match_cand = is_seq && (class_to_mode(cls) == cand);
  assign match_mode = is_seq && (class_to_mode(cls) == mode_q);

  // A matching step that lands numerically on the "wrong side" of prev has
  // crossed the 15/0 boundary.
  assign wraps = (mode_q == MODE_DOWN) ? (bus.count > prev) : (bus.count < prev);

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      // NOTE: every flop here is a plain register (no memory array), so all of them get an async reset.
      state     <= EMPTY;
      prev      <= 4'd0;
      cand      <= MODE_UP;
      mode_q    <= MODE_UP;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      // Pulses last exactly one cycle unless re-triggered below.
      err_q  <= 1'b0;
      wrap_q <= 1'b0;

      if (bus.sample) begin
        case (state)
          // No reference value exists yet, so a step cannot be a stall here.
          EMPTY: begin
            prev  <= bus.count;
            state <= ACQ1;
          end

          ACQ1: begin
            if (!is_stall) begin
              prev <= bus.count;
              if (is_seq) begin
                cand  <= class_to_mode(cls);
                state <= ACQ2;
              end
            end
          end

          ACQ2: begin
            if (!is_stall) begin
              prev <= bus.count;
              if (match_cand) begin
                mode_q   <= cand;
                locked_q <= 1'b1;
                state    <= LOCK;
              end else if (is_seq) begin
                cand <= class_to_mode(cls);
              end else begin
                state <= ACQ1;
              end
            end
          end

          LOCK: begin
            if (!is_stall) begin
              // Resync on the current sample even on a violation; mode keeps
              // its last value so software can see what was being tracked.
              prev <= bus.count;
              if (match_mode) begin
                wrap_q <= wraps;
              end else begin
                err_q    <= 1'b1;
                locked_q <= 1'b0;
                state    <= ACQ1;
                if (err_cnt_q != '1) begin
                  err_cnt_q <= err_cnt_q + ERR_W'(1);
                end
              end
            end
          end

          default: state <= EMPTY;
        endcase
      end
    end
  end

  assign bus.mode    = mode_q;
  assign bus.locked  = locked_q;
  assign bus.err     = err_q;
  assign bus.wrap    = wrap_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 The block SHALL have parameter ERR_W, default 8, setting the width of the error counter.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Clear, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port sample, input, 1 bit: one-cycle strobe, count valid this cycle.
REQ-005 The block SHALL have port count, input, 4 bits: counter value under observation.
REQ-006 The block SHALL have port mode, output, 2 bits: detected sequence (00 up, 01 down, 10 even, 11 odd).
REQ-007 The block SHALL have port locked, output, 1 bit: mode valid, sequence being checked.
REQ-008 The block SHALL have port err, output, 1 bit: one-cycle pulse on a sequence violation while locked.
REQ-009 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when a locked sequence wraps modulo 16.
REQ-010 The block SHALL have port err_cnt, output, ERR_W bits: saturating violation count.

Function
REQ-011 The block SHALL act only on cycles with sample=1; with sample=0, state and outputs other than the err/wrap pulses SHALL hold.
REQ-012 The block SHALL compute delta = (count - prev) mod 16 on each sample, where prev is the last accepted sample.
REQ-013 The block SHALL classify delta as: 1 -> up; 15 -> down; 2 with count[0]=0 -> even; 2 with count[0]=1 -> odd; 0 -> stall; any other value -> invalid.
REQ-014 On stall (delta 0), the block SHALL ignore the sample in every state: no prev update, no pulse, no transition.
REQ-015 The block SHALL have FSM states EMPTY (no prev), ACQ1 (prev held), ACQ2 (candidate mode held), and LOCK.
REQ-016 In EMPTY, a sample SHALL store prev and transition to ACQ1.
REQ-017 In ACQ1, a valid delta SHALL store candidate and go to ACQ2; an invalid delta SHALL stay in ACQ1; prev SHALL update in both cases.
REQ-018 In ACQ2, a delta matching candidate SHALL go to LOCK with mode=candidate.
REQ-019 In ACQ2, a valid non-matching delta SHALL replace candidate and stay in ACQ2.
REQ-020 In ACQ2, an invalid delta SHALL go to ACQ1.
REQ-021 In LOCK, a matching delta SHALL stay in LOCK.
REQ-022 In LOCK, any non-matching non-stall delta SHALL pulse err, increment err_cnt, and go to ACQ1.
REQ-023 In LOCK, any non-matching non-stall delta SHALL keep the current sample as prev (resync) and keep mode at its last value.
REQ-024 The block SHALL saturate err_cnt at all-ones, with no wrap to 0.
REQ-025 In LOCK, with a matching delta, wrap SHALL pulse when count < prev for up/even/odd, or count > prev for down.
REQ-026 All outputs SHALL be registered, with 1-cycle latency from the sample cycle to the locked/mode/err/wrap/err_cnt update.
REQ-027 The locked output SHALL be 1 exactly when the state is LOCK.
REQ-028 The err and wrap outputs SHALL never assert in the same cycle.
REQ-029 The err and wrap outputs SHALL deassert in the cycle following their assertion unless retriggered.

Reset
REQ-030 When Clear asserts, asynchronously, the block SHALL set state=EMPTY, prev=0, candidate=00, mode=00, locked=0, err=0, wrap=0, err_cnt=0.
REQ-031 Clear asserted mid-operation SHALL discard any partial acquisition.
REQ-032 A sample coincident with Clear SHALL be ignored.
REQ-033 After Clear deasserts, the first sample SHALL be treated as in EMPTY.

Structure
REQ-034 Mode encodings (UP=00, DOWN=01, EVEN=10, ODD=11) SHALL live in shared package count_pkg, matching the counter-select encoding.
REQ-035 The delta class codes (UP, DOWN, EVEN, ODD, STALL, INVALID) SHALL also live in count_pkg.
REQ-036 FSM state encoding SHALL be local to the module.
REQ-037 The combinational delta classifier SHALL be sub-module count_delta_classify (inputs count, prev; output class).

Verification
REQ-038 Bench SHALL cover: Clear, then samples 0,1,2,3 -> locked=1 after the 3rd sample's next cycle, mode=00, err=0.
REQ-039 Bench SHALL cover: samples 2,1,0,15 -> locked with mode=01; the sample 15 -> wrap pulse one cycle.
REQ-040 Bench SHALL cover: samples 1,3,5, then 7, then 6 -> mode=11 locked; on 6, err pulse, err_cnt=1, locked=0; then 7,8 -> relock mode=00.
REQ-041 Bench SHALL cover: samples 4,4,6,6,8 (stalls) -> locked with mode=10, no err.
REQ-042 Bench SHALL cover: ERR_W=2 with five forced violations -> err_cnt reaches 3 and holds.
REQ-043 Bench SHALL cover: Clear pulsed mid-LOCK, asynchronously between clock edges -> all outputs 0 immediately; next samples 9,10,11 -> relock mode=00.
